seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised serial shift-add multiplier: controller and datapath in one block, N-bit operands, one partial-product step per clock. Supports unsigned mode and signed two's-complement mode (radix-2 Booth recoding). Adds an abort input and a start/ready/done handshake. It is the next generation of the 4-bit shift-add sequencer and is used as the arithmetic unit wherever a multiplier of arbitrary width is needed.

## Interface
- N, 8, operand width; N >= 2
- CW, $clog2(N)+1, step-counter width; must be able to hold N
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- start  in  1  request a multiplication; sampled in IDLE and DONE only
- signed_mode  in  1  0 = unsigned, 1 = signed (Booth); latched with the operands at start
- a  in  N  multiplicand; latched at start
- b  in  N  multiplier; latched at start
- abort  in  1  cancels a multiplication in progress
- product  out  2N  result register; holds its value until the next completion or reset
- busy  out  1  high while in RUN
- ready  out  1  high while in DONE; product is valid
- done  out  1  one-cycle pulse on the first cycle of DONE

## Operation
- Internal registers: M (N bits), ACC (N+1 bits), Q (N bits), q_1 (1 bit), count (CW bits), mode (1 bit), state.
- States: IDLE, RUN, DONE. Unused encodings go to IDLE.
- IDLE: when start = 1, load M <= a, Q <= b, ACC <= 0, q_1 <= 0, count <= N, mode <= signed_mode, then go to RUN. Otherwise stay in IDLE.
- RUN, unsigned step: if Q[0] = 1, then S = ACC + zero-extended M, else S = ACC. Shift {S, Q} right by one with a 0 fill into the top bit.
- RUN, signed step: decode {Q[0], q_1}.
  - 01: S = ACC + sign-extended M.
  - 10: S = ACC - sign-extended M.
  - 00 or 11: S = ACC.
  - Arithmetic-shift {S, Q, q_1} right by one, replicating S[N].
- The N+1-bit ACC prevents overflow, including M = -2^(N-1).
- Every RUN cycle decrements count. When the decremented count is 0, load product <= {ACC[N-1:0], Q} from the shifted values and go to DONE.
- DONE: ready = 1; done = 1 on the entry cycle only. When start = 1, reload the operands exactly as in IDLE and go to RUN; ready drops on the next cycle.
- start during RUN is ignored.
- abort during RUN: go to IDLE. product keeps its previous value; ready and done stay 0; no done pulse. abort has priority over the final step.
- abort in IDLE or DONE has no effect.
- reset (any time, including mid-RUN): state becomes IDLE. product, ACC, Q, M, q_1, count and mode are cleared to 0. busy, ready and done are 0.

## Timing
- busy, ready and done are decoded from state: registered and glitch-free, with no combinational path from inputs.
- Edge numbering: start is sampled high at edge 0 in IDLE or DONE.
  - busy = 1 from after edge 0 through edge N-1, i.e. N cycles.
  - product is valid, ready = 1 and done = 1 after edge N.
  - done deasserts after edge N+1.
- Latency is N clocks from start to ready. Throughput is one result per N+1 clocks with start held high.
- Restart from DONE: the same timing applies. product keeps the old result until the new one is loaded at edge N.
- abort sampled at edge k, with 1 <= k <= N: busy = 0 after edge k. The next start may be sampled at edge k+1.
- Operand inputs only need to be stable at the start edge.

## Test plan
- Unsigned, N=8, a=13, b=11, start for 1 cycle -> busy high for exactly 8 cycles; product=0x008F; ready=1; one-cycle done.
- Unsigned extremes, a=255, b=255 -> product=0xFE01. a=0, b=200 -> product=0x0000, same latency.
- Signed, N=8:
  - a=-3, b=5 -> product=0xFFF1.
  - a=-128, b=-128 -> product=0x4000.
  - a=127, b=-128 -> product=0xC080.
- Abort: after the 0x008F result, start a=7, b=9 and assert abort at RUN cycle 3 -> IDLE; busy=0; ready=0; no done pulse; product remains 0x008F. Also pulse start mid-run with no abort -> no effect, result 63 delivered on time.
- Back-to-back: hold start high in DONE with new operands (a=2, b=3) -> ready drops after 1 cycle; product=6 exactly N clocks later.
- Asynchronous reset asserted between clock edges mid-RUN -> immediately IDLE with product=0, busy=ready=done=0. A subsequent start completes normally.

Source files
------------

// File: rtl/seq_multiplier.sv
// Serial shift-add multiplier with unsigned and radix-2 Booth signed modes.
// One partial-product step per clock, start/ready/done handshake and abort.
module seq_multiplier #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           abort,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           ready,
    output logic           done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic [N-1:0]   m_r;
    logic [N:0]     acc_r;
    logic [N-1:0]   q_r;
    logic           q_1_r;
    logic [CW-1:0]  count_r;
    logic           mode_r;
    logic [2*N-1:0] product_r;
    logic           busy_r;
    logic           ready_r;
    logic           done_r;

    logic [N:0]     sum_s;
    logic [N:0]     acc_sh_s;
    logic [N-1:0]   q_sh_s;
    logic [CW-1:0]  count_dec_s;
    logic           load_s;
    logic           step_s;
    logic           finish_s;

    // One shift-add (unsigned) or Booth (signed) step on the current registers.
    always_comb begin
        sum_s    = acc_r;
        acc_sh_s = {1'b0, acc_r[N:1]};
        if (mode_r) begin
            case ({q_r[0], q_1_r})
                2'b01:   sum_s = acc_r + {m_r[N-1], m_r};
                2'b10:   sum_s = acc_r - {m_r[N-1], m_r};
                default: sum_s = acc_r;
            endcase
            acc_sh_s = {sum_s[N], sum_s[N:1]};
        end else begin
            if (q_r[0]) begin
                sum_s = acc_r + {1'b0, m_r};
            end else begin
                sum_s = acc_r;
            end
            acc_sh_s = {1'b0, sum_s[N:1]};
        end
        q_sh_s      = {sum_s[0], q_r[N-1:1]};
        count_dec_s = count_r - {{(CW-1){1'b0}}, 1'b1};
    end

    // Next-state decode; abort wins over the final step.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_s       = 1'b1;
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (count_dec_s == {CW{1'b0}}) begin
                    step_s       = 1'b1;
                    finish_s     = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    step_s       = 1'b1;
                    next_state_s = ST_RUN;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, datapath and handshake registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            m_r       <= {N{1'b0}};
            acc_r     <= {(N+1){1'b0}};
            q_r       <= {N{1'b0}};
            q_1_r     <= 1'b0;
            count_r   <= {CW{1'b0}};
            mode_r    <= 1'b0;
            product_r <= {(2*N){1'b0}};
            busy_r    <= 1'b0;
            ready_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (load_s) begin
                m_r     <= a;
                acc_r   <= {(N+1){1'b0}};
                q_r     <= b;
                q_1_r   <= 1'b0;
                count_r <= CW'(N);
                mode_r  <= signed_mode;
            end else if (step_s) begin
                acc_r   <= acc_sh_s;
                q_r     <= q_sh_s;
                q_1_r   <= q_r[0];
                count_r <= count_dec_s;
            end
            if (finish_s) begin
                product_r <= {acc_sh_s[N-1:0], q_sh_s};
            end
            busy_r  <= (next_state_s == ST_RUN);
            ready_r <= (next_state_s == ST_DONE);
            done_r  <= finish_s;
        end
    end

    assign product = product_r;
    assign busy    = busy_r;
    assign ready   = ready_r;
    assign done    = done_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, hand-written corner
// sequences and randomized operands against an arithmetic reference model.
module tb_seq_multiplier;
    localparam int N = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           abort = 1'b0;
    logic [2*N-1:0] product;
    logic           busy;
    logic           ready;
    logic           done;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] last_prod = '0;

    seq_multiplier #(.N(N)) dut (
        .clock(clock), .reset(reset), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .abort(abort), .product(product),
        .busy(busy), .ready(ready), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0]   va;
        logic [N-1:0]   vb;
        logic           sm;
        logic [2*N-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                               input logic sm);
        longint sx, sy, p;
        if (sm) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'(x);
            sy = longint'(y);
        end
        p = sx * sy;
        return p[2*N-1:0];
    endfunction

    // Starts at a negedge in IDLE/DONE; returns at the negedge of the done cycle.
    task automatic run_mult(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic sm,
                            input logic [2*N-1:0] exp, input string name);
        int cyc;
        a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({name, " ready_drop"}, 32'(ready), 32'd0);
        check({name, " old_product"}, 32'(product), 32'(last_prod));
        cyc = 0;
        while (busy && cyc < 4*N) begin
            cyc++;
            @(negedge clock);
        end
        check({name, " latency"}, cyc, N);
        check({name, " ready"}, 32'(ready), 32'd1);
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " product"}, 32'(product), 32'(exp));
        last_prod = exp;
    endtask

    task automatic done_tail(input string name);
        @(negedge clock);
        check({name, " done_pulse_end"}, 32'(done), 32'd0);
        check({name, " ready_hold"}, 32'(ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[7];
        int   cyc;
        int   done_seen;
        logic [N-1:0] ra, rb;
        logic rs;

        vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F};
        vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 1'b0, 16'h0000};
        vecs[3] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1};
        vecs[4] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[5] = '{8'd127, 8'h80,  1'b1, 16'hC080};
        vecs[6] = '{8'd7,   8'd9,   1'b0, 16'd63};

        repeat (2) @(negedge clock);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ready", 32'(ready), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_mult(8'd13, 8'd11, 1'b0, 16'h008F, "u13x11");
        done_tail("u13x11");

        // Abort at RUN edge 3: back to IDLE, no done, product kept.
        a = 8'd7; b = 8'd9; signed_mode = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort ready", 32'(ready), 32'd0);
        check("abort product", 32'(product), 32'h008F);
        done_seen = 0;
        for (int i = 0; i < N; i++) begin
            if (done || ready || busy) done_seen++;
            @(negedge clock);
        end
        check("abort quiet", done_seen, 0);

        // Start pulsed mid-run is ignored.
        a = 8'd7; b = 8'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 4*N) begin
            cyc++;
            if (cyc == 3) begin a = 8'd1; b = 8'd1; start = 1'b1; end
            else start = 1'b0;
            @(negedge clock);
        end
        start = 1'b0;
        check("midstart latency", cyc, N);
        check("midstart product", 32'(product), 32'd63);
        check("midstart done", 32'(done), 32'd1);
        last_prod = 16'd63;

        // Back-to-back restart on the first DONE cycle.
        run_mult(8'd2, 8'd3, 1'b0, 16'd6, "b2b");
        run_mult(8'd5, 8'd6, 1'b0, 16'd30, "b2b_again");
        done_tail("b2b_again");

        // Asynchronous reset between clock edges mid-RUN.
        a = 8'd100; b = 8'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("areset busy", 32'(busy), 32'd0);
        check("areset ready", 32'(ready), 32'd0);
        check("areset done", 32'(done), 32'd0);
        check("areset product", 32'(product), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        last_prod = '0;
        @(negedge clock);
        run_mult(8'd12, 8'd12, 1'b0, 16'd144, "after_reset");
        done_tail("after_reset");

        for (int i = 0; i < 7; i++) begin
            run_mult(vecs[i].va, vecs[i].vb, vecs[i].sm, vecs[i].exp, $sformatf("vec%0d", i));
            done_tail($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rs = 1'($urandom_range(1, 0));
            run_mult(ra, rb, rs, ref_mul(ra, rb, rs), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
